// File: rtl/dor_input_debounce_if.sv
// dor_input_debounce_if
//   Signal bundle between raw switch lines and the debounced a/b levels that
//   feed the dor OR stage.
//   sw_a_in, sw_b_in : raw, asynchronous, bouncing switch lines
//   a, b             : debounced levels (connect to dor.a / dor.b)
//   a_chg, b_chg     : one-cycle strobes, asserted in the cycle a/b change
//   master : switch/stimulus side (drives sw_*, observes outputs)
//   slave  : debouncer side (observes sw_*, drives outputs)
interface dor_input_debounce_if;
  logic sw_a_in;
  logic sw_b_in;
  logic a;
  logic b;
  logic a_chg;
  logic b_chg;

  modport master (
    output sw_a_in, sw_b_in,
    input  a, b, a_chg, b_chg
  );

  modport slave (
    input  sw_a_in, sw_b_in,
    output a, b, a_chg, b_chg
  );
endinterface

// File: rtl/dor_input_debounce.sv
// dor_input_debounce
//   Two independent channels, each a SYNC_STAGES-deep synchroniser followed by
//   a debounce FSM. The output level follows the synchronised input only after
//   the input has differed from the output for STABLE_CYCLES consecutive
//   cycles; any shorter excursion is discarded and every bounce back restarts
//   qualification. Each update is flagged by a registered one-cycle strobe.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears all state
//   bus : slave side of dor_input_debounce_if (sw_a_in/sw_b_in in,
//         a/b/a_chg/b_chg out)
module dor_input_debounce #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  dor_input_debounce_if.slave  bus
);

  typedef enum logic {
    IDLE,
    QUALIFY
  } state_e;

  // Final count value: reaching it on a still-differing input commits the change.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [1:0] raw;
  logic [1:0] lvl;
  logic [1:0] chg;

  assign raw = {bus.sw_b_in, bus.sw_a_in};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   lvl_q, lvl_d;
    logic                   chg_q, chg_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q  <= '0;
        state_q <= IDLE;
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        chg_q   <= 1'b0;
      end else begin
        sync_q  <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
        state_q <= state_d;
        cnt_q   <= cnt_d;
        lvl_q   <= lvl_d;
        chg_q   <= chg_d;
      end
    end

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      chg_d   = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (s != lvl_q) begin
            state_d = QUALIFY;
            cnt_d   = CNT_W'(1);
          end
        end
        QUALIFY: begin
          if (s == lvl_q) begin
            // Bounced back: drop the partial count, level untouched.
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            lvl_d   = s;
            chg_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign lvl[ch] = lvl_q;
    assign chg[ch] = chg_q;
  end

  assign bus.a     = lvl[0];
  assign bus.b     = lvl[1];
  assign bus.a_chg = chg[0];
  assign bus.b_chg = chg[1];

endmodule

// File: tb/tb_dor_input_debounce.sv
// tb_dor_input_debounce
//   Bench for dor_input_debounce. A reference model predicts, per channel, the
//   edge on which each debounced level change happens and queues it; a monitor
//   on the falling edge pops and compares whenever a strobe appears, and also
//   tracks the expected levels every cycle.
module tb_dor_input_debounce;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int LAT    = SYNC + STABLE;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dor_input_debounce_if bus ();

  dor_input_debounce #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .CNT_W        (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  function automatic void chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, got, exp, edge_n);
    end
  endfunction

  // ---------------- reference model ----------------
  // raw_hist: raw samples of the last SYNC edges, [0] oldest -> value the
  // debouncer sees this edge. s_hist: last STABLE observed values; the level
  // flips when all of them disagree with it.
  typedef struct {
    int edge_no;
    bit level;
  } ev_t;

  bit  raw_hist [2][SYNC];
  bit  s_hist   [2][STABLE];
  bit  mq       [2];
  ev_t exp_a[$];
  ev_t exp_b[$];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mq[c] = 1'b0;
      for (int i = 0; i < SYNC; i++)   raw_hist[c][i] = 1'b0;
      for (int i = 0; i < STABLE; i++) s_hist[c][i]   = 1'b0;
    end
    exp_a.delete();
    exp_b.delete();
  endtask

  task automatic model_step(input int c, input bit raw);
    bit  s;
    bit  all_diff;
    ev_t ev;
    s = raw_hist[c][0];
    for (int i = 0; i < SYNC - 1; i++) raw_hist[c][i] = raw_hist[c][i+1];
    raw_hist[c][SYNC-1] = raw;
    for (int i = 0; i < STABLE - 1; i++) s_hist[c][i] = s_hist[c][i+1];
    s_hist[c][STABLE-1] = s;
    all_diff = 1'b1;
    for (int i = 0; i < STABLE; i++)
      if (s_hist[c][i] == mq[c]) all_diff = 1'b0;
    if (all_diff) begin
      mq[c]       = ~mq[c];
      ev.edge_no  = edge_n;
      ev.level    = mq[c];
      if (c == 0) exp_a.push_back(ev);
      else        exp_b.push_back(ev);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin
      edge_n++;
      model_step(0, bus.sw_a_in);
      model_step(1, bus.sw_b_in);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit prev_a = 1'b0, prev_b = 1'b0, prev_ca = 1'b0, prev_cb = 1'b0;
  int strobes_a = 0;

  task automatic score(input string tag, input bit q, input bit c, input bit prev_q,
                       input bit prev_c, input int ch);
    ev_t ev;
    chk({"level_", tag}, int'(q), int'(mq[ch]));
    chk({"strobe_vs_level_", tag}, int'(c), int'(q != prev_q));
    if (c) begin
      chk({"no_back_to_back_", tag}, int'(prev_c), 0);
      if ((ch == 0 && exp_a.size() == 0) || (ch == 1 && exp_b.size() == 0)) begin
        chk({"unexpected_strobe_", tag}, 1, 0);
      end else begin
        ev = (ch == 0) ? exp_a.pop_front() : exp_b.pop_front();
        chk({"strobe_edge_", tag}, edge_n, ev.edge_no);
        chk({"strobe_level_", tag}, int'(q), int'(ev.level));
      end
    end
    if (ch == 0 && exp_a.size() > 0 && exp_a[0].edge_no < edge_n) begin
      chk({"missed_strobe_", tag}, 0, 1);
      void'(exp_a.pop_front());
    end
    if (ch == 1 && exp_b.size() > 0 && exp_b[0].edge_no < edge_n) begin
      chk({"missed_strobe_", tag}, 0, 1);
      void'(exp_b.pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs", int'({bus.a, bus.b, bus.a_chg, bus.b_chg}), 0);
      prev_a = 1'b0; prev_b = 1'b0; prev_ca = 1'b0; prev_cb = 1'b0;
    end else begin
      score("a", bus.a, bus.a_chg, prev_a, prev_ca, 0);
      score("b", bus.b, bus.b_chg, prev_b, prev_cb, 1);
      if (bus.a_chg) strobes_a++;
      prev_a = bus.a; prev_b = bus.b; prev_ca = bus.a_chg; prev_cb = bus.b_chg;
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_chg(input int ch, input string name, output int got_edge);
    bit seen;
    seen = 1'b0;
    got_edge = -1;
    for (int i = 0; i < 4 * LAT && !seen; i++) begin
      @(negedge clk);
      if ((ch == 0 && bus.a_chg) || (ch == 1 && bus.b_chg)) begin
        seen = 1'b1;
        got_edge = edge_n;
      end
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic apply_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    bus.sw_a_in = 1'b0;
    bus.sw_b_in = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0, ge, ga, gb, cnt0;
    bus.sw_a_in = 1'b0;
    bus.sw_b_in = 1'b0;

    // 1: quiet after reset
    apply_reset();
    idle(20);
    chk("quiet_levels", int'({bus.a, bus.b}), 0);

    // 2: single clean rise on A
    k0 = edge_n;
    bus.sw_a_in = 1'b1;
    wait_chg(0, "rise_a", ge);
    chk("rise_a_latency", ge, k0 + LAT);
    chk("rise_a_level", int'(bus.a), 1);
    idle(3);

    // 3: short pulse on B is rejected
    bus.sw_b_in = 1'b1;
    idle(5);
    bus.sw_b_in = 1'b0;
    idle(20);
    chk("pulse_b_rejected", int'(bus.b), 0);

    // 4: A bouncing every 3 cycles, then settling high
    apply_reset();
    idle(2);
    cnt0 = strobes_a;
    for (int t = 0; t < 10; t++) begin
      bus.sw_a_in = ~bus.sw_a_in;
      idle(3);
    end
    k0 = edge_n;
    bus.sw_a_in = 1'b1;
    wait_chg(0, "bounce_a", ge);
    chk("bounce_a_latency", ge, k0 + LAT);
    idle(5);
    chk("bounce_a_single_strobe", strobes_a - cnt0, 1);

    // 5: both channels rise together, then fall together
    apply_reset();
    idle(2);
    k0 = edge_n;
    bus.sw_a_in = 1'b1;
    bus.sw_b_in = 1'b1;
    fork
      wait_chg(0, "both_rise_a", ga);
      wait_chg(1, "both_rise_b", gb);
    join
    chk("both_rise_same_edge", ga, gb);
    chk("both_rise_latency", ga, k0 + LAT);
    idle(2);
    k0 = edge_n;
    bus.sw_a_in = 1'b0;
    bus.sw_b_in = 1'b0;
    fork
      wait_chg(0, "both_fall_a", ga);
      wait_chg(1, "both_fall_b", gb);
    join
    chk("both_fall_same_edge", ga, gb);
    chk("both_fall_latency", gb, k0 + LAT);
    chk("both_fall_levels", int'({bus.a, bus.b}), 0);

    // 6: reset in the middle of qualification, and during a strobe
    apply_reset();
    idle(2);
    k0 = edge_n;
    bus.sw_a_in = 1'b1;
    while (edge_n < k0 + 7) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("midqual_reset_outputs", int'({bus.a, bus.a_chg}), 0);
    idle(2);
    rst = 1'b0;
    k0 = edge_n;
    wait_chg(0, "post_reset_rise", ge);
    chk("post_reset_latency", ge, k0 + LAT);
    #1 rst = 1'b1;
    #1 chk("strobe_reset_outputs", int'({bus.a, bus.a_chg}), 0);
    idle(2);
    rst = 1'b0;
    k0 = edge_n;
    wait_chg(0, "rerise", ge);
    chk("rerise_latency", ge, k0 + LAT);

    // random bouncing on both channels
    apply_reset();
    begin
      int hold_a, hold_b;
      hold_a = 0;
      hold_b = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (hold_a == 0) begin
          bus.sw_a_in = 1'($urandom_range(0, 1));
          hold_a = int'($urandom_range(1, 14));
        end
        if (hold_b == 0) begin
          bus.sw_b_in = 1'($urandom_range(0, 1));
          hold_b = int'($urandom_range(1, 14));
        end
        hold_a--;
        hold_b--;
        idle(1);
      end
    end
    idle(LAT + 4);
    chk("drain_a", exp_a.size(), 0);
    chk("drain_b", exp_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
